// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with modulo terminal value, clamped parallel load and
// registered carry/borrow pulses. Define COUNTER_UPDOWN_SATURATE_EN to saturate at the bounds.
module counter_updown_param #(
   parameter int unsigned       WIDTH   = 8,
   parameter logic [WIDTH-1:0]  MAX_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             count_en_i,
   input  logic             up_down_i,
   output logic [WIDTH-1:0] count_o,
   output logic             carry_o,
   output logic             borrow_o,
   output logic             at_max_o,
   output logic             at_zero_o
);

   localparam logic [WIDTH-1:0] One  = WIDTH'(1);
   localparam logic [WIDTH-1:0] Zero = '0;

   logic [WIDTH-1:0] count_q, count_d;
   logic             carry_q, carry_d;
   logic             borrow_q, borrow_d;

   always_comb begin
      count_d  = count_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      if (load_i) begin
         count_d = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;
      end else if (count_en_i) begin
         if (up_down_i) begin
            // >= rather than == keeps the counter in range even from an unexpected state
            if (count_q >= MAX_VAL) begin
`ifdef COUNTER_UPDOWN_SATURATE_EN
               count_d = MAX_VAL;
`else
               count_d = Zero;
`endif
               carry_d = 1'b1;
            end else begin
               count_d = count_q + One;
            end
         end else begin
            if (count_q == Zero) begin
`ifdef COUNTER_UPDOWN_SATURATE_EN
               count_d = Zero;
`else
               count_d = MAX_VAL;
`endif
               borrow_d = 1'b1;
            end else begin
               count_d = count_q - One;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q  <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
      end
   end

   assign count_o   = count_q;
   assign carry_o   = carry_q;
   assign borrow_o  = borrow_q;
   assign at_max_o  = (count_q == MAX_VAL);
   assign at_zero_o = (count_q == Zero);

endmodule
